stdp_synapse: RTL and testbench



---
 rtl/stdp_pkg.sv | 53 +++++
 rtl/spike_timer.sv | 45 ++++
 rtl/stdp_synapse.sv | 105 ++++++++++
 tb/tb_stdp_synapse.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared widths, learning-curve defaults and saturating weight arithmetic
// for the pair-based STDP synapse.
package stdp_pkg;

    localparam int W_WIDTH = 8;
    localparam int T_WIDTH = 4;
    localparam int WINDOW  = 15;
    localparam int A_PLUS  = 8;
    localparam int A_MINUS = 8;
    localparam int W_INIT  = 128;

    localparam logic [W_WIDTH-1:0] W_MAX = {W_WIDTH{1'b1}};

    // Add with one guard bit, then clamp to the top of the weight range.
    function automatic logic [W_WIDTH-1:0] sat_add(
        input logic [W_WIDTH-1:0] w,
        input logic [W_WIDTH-1:0] d
    );
        logic [W_WIDTH:0] sum;
        sum = {1'b0, w} + {1'b0, d};
        if (sum[W_WIDTH]) begin
            sat_add = W_MAX;
        end else begin
            sat_add = sum[W_WIDTH-1:0];
        end
    endfunction

    function automatic logic [W_WIDTH-1:0] sat_sub(
        input logic [W_WIDTH-1:0] w,
        input logic [W_WIDTH-1:0] d
    );
        if (d > w) begin
            sat_sub = {W_WIDTH{1'b0}};
        end else begin
            sat_sub = w - d;
        end
    endfunction

    // Linear decay of the learning curve: peak at dt=0, zero once dt reaches the peak.
    function automatic logic [W_WIDTH-1:0] decay_step(
        input int                 peak,
        input logic [T_WIDTH-1:0] dt
    );
        int dt_i;
        dt_i = int'(dt);
        if (peak > dt_i) begin
            decay_step = W_WIDTH'(peak - dt_i);
        end else begin
            decay_step = {W_WIDTH{1'b0}};
        end
    endfunction

endpackage

// File: rtl/spike_timer.sv
// Saturating time-since-last-spike counter; WINDOW means "no recent spike".
module spike_timer #(
    parameter int T_WIDTH = stdp_pkg::T_WIDTH,
    parameter int WINDOW  = stdp_pkg::WINDOW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spike,
    output logic [T_WIDTH-1:0] cnt,
    output logic               recent
);

    localparam logic [T_WIDTH-1:0] WIN = T_WIDTH'(WINDOW);

    logic [T_WIDTH-1:0] cnt_nxt_s;
    logic [T_WIDTH-1:0] cnt_r;
    logic               recent_r;

    // Next count: clear on spike, otherwise count up and stick at WINDOW.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (spike) begin
            cnt_nxt_s = {T_WIDTH{1'b0}};
        end else if (cnt_r < WIN) begin
            cnt_nxt_s = cnt_r + T_WIDTH'(1);
        end else begin
            cnt_nxt_s = WIN;
        end
    end

    // Counter and its registered "recent" qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= WIN;
            recent_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            recent_r <= (cnt_nxt_s < WIN);
        end
    end

    assign cnt    = cnt_r;
    assign recent = recent_r;

endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP stage: times pre/post spikes and nudges an unsigned weight
// up (post after pre) or down (pre after post) by a linearly decaying step.
module stdp_synapse #(
    parameter int W_WIDTH = stdp_pkg::W_WIDTH,
    parameter int T_WIDTH = stdp_pkg::T_WIDTH,
    parameter int WINDOW  = stdp_pkg::WINDOW,
    parameter int A_PLUS  = stdp_pkg::A_PLUS,
    parameter int A_MINUS = stdp_pkg::A_MINUS,
    parameter int W_INIT  = stdp_pkg::W_INIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pre_spike,
    input  logic               post_spike,
    input  logic               learn_en,
    input  logic               w_load,
    input  logic [W_WIDTH-1:0] w_load_val,
    output logic [W_WIDTH-1:0] weight,
    output logic               update_w_flag,
    output logic               ltp_dir,
    output logic [T_WIDTH-1:0] time_diff
);
    import stdp_pkg::*;

    logic [T_WIDTH-1:0] pre_cnt_s;
    logic [T_WIDTH-1:0] post_cnt_s;
    logic               pre_recent_s;
    logic               post_recent_s;
    logic               ltp_s;
    logic               ltd_s;
    logic [T_WIDTH-1:0] dt_s;
    logic [W_WIDTH-1:0] weight_nxt_s;

    logic [W_WIDTH-1:0] weight_r;
    logic               flag_r;
    logic               ltp_dir_r;
    logic [T_WIDTH-1:0] time_diff_r;

    spike_timer #(
        .T_WIDTH(T_WIDTH),
        .WINDOW (WINDOW)
    ) u_pre_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .spike (pre_spike),
        .cnt   (pre_cnt_s),
        .recent(pre_recent_s)
    );

    spike_timer #(
        .T_WIDTH(T_WIDTH),
        .WINDOW (WINDOW)
    ) u_post_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .spike (post_spike),
        .cnt   (post_cnt_s),
        .recent(post_recent_s)
    );

    // Classify the current spike pair and precompute the candidate weight.
    // A coincident pre+post pulse is neither LTP nor LTD.
    always_comb begin
        ltp_s        = post_spike & ~pre_spike & pre_recent_s;
        ltd_s        = pre_spike & ~post_spike & post_recent_s;
        dt_s         = {T_WIDTH{1'b0}};
        weight_nxt_s = weight_r;
        if (ltp_s) begin
            dt_s         = pre_cnt_s + T_WIDTH'(1);
            weight_nxt_s = sat_add(weight_r, decay_step(A_PLUS, dt_s));
        end else if (ltd_s) begin
            dt_s         = post_cnt_s + T_WIDTH'(1);
            weight_nxt_s = sat_sub(weight_r, decay_step(A_MINUS, dt_s));
        end else begin
            dt_s         = {T_WIDTH{1'b0}};
            weight_nxt_s = weight_r;
        end
    end

    // Weight and event reporting; an explicit load overrides any learning event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_r    <= W_WIDTH'(W_INIT);
            flag_r      <= 1'b0;
            ltp_dir_r   <= 1'b0;
            time_diff_r <= {T_WIDTH{1'b0}};
        end else if (w_load) begin
            weight_r <= w_load_val;
            flag_r   <= 1'b0;
        end else if (learn_en && (ltp_s || ltd_s)) begin
            weight_r    <= weight_nxt_s;
            flag_r      <= 1'b1;
            ltp_dir_r   <= ltp_s;
            time_diff_r <= dt_s;
        end else begin
            flag_r <= 1'b0;
        end
    end

    assign weight        = weight_r;
    assign update_w_flag = flag_r;
    assign ltp_dir       = ltp_dir_r;
    assign time_diff     = time_diff_r;

endmodule

// File: tb/tb_stdp_synapse.sv
// Self-checking bench for stdp_synapse: directed scenarios with fixed
// expectations plus a randomized run against a spike-time reference model.
module tb_stdp_synapse;

    localparam int WINDOW  = 15;
    localparam int A_PLUS  = 8;
    localparam int A_MINUS = 8;
    localparam int WMAX    = 255;
    localparam int WINIT   = 128;

    logic       clk;
    logic       rst_n;
    logic       pre_spike;
    logic       post_spike;
    logic       learn_en;
    logic       w_load;
    logic [7:0] w_load_val;
    logic [7:0] weight;
    logic       update_w_flag;
    logic       ltp_dir;
    logic [3:0] time_diff;

    int n_checks;
    int n_fail;

    // Reference model state: absolute edge index of last spikes (-1 = none).
    int cyc;
    int last_pre;
    int last_post;
    int m_w;
    int m_flag;
    int m_dir;
    int m_td;

    logic [13:0] got;

    stdp_synapse dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .learn_en     (learn_en),
        .w_load       (w_load),
        .w_load_val   (w_load_val),
        .weight       (weight),
        .update_w_flag(update_w_flag),
        .ltp_dir      (ltp_dir),
        .time_diff    (time_diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    task automatic model_reset();
        cyc       = 0;
        last_pre  = -1;
        last_post = -1;
        m_w       = WINIT;
        m_flag    = 0;
        m_dir     = 0;
        m_td      = 0;
    endtask

    task automatic model_edge(input logic p, input logic q, input logic l,
                              input logic ld, input logic [7:0] v);
        int dt;
        int d;
        cyc    = cyc + 1;
        m_flag = 0;
        if (ld) begin
            m_w = int'(v);
        end else if (l) begin
            if (q && !p && last_pre >= 0 && (cyc - last_pre) <= WINDOW) begin
                dt     = cyc - last_pre;
                d      = (A_PLUS > dt) ? A_PLUS - dt : 0;
                m_w    = (m_w + d > WMAX) ? WMAX : m_w + d;
                m_flag = 1;
                m_dir  = 1;
                m_td   = dt;
            end else if (p && !q && last_post >= 0 && (cyc - last_post) <= WINDOW) begin
                dt     = cyc - last_post;
                d      = (A_MINUS > dt) ? A_MINUS - dt : 0;
                m_w    = (m_w - d < 0) ? 0 : m_w - d;
                m_flag = 1;
                m_dir  = 0;
                m_td   = dt;
            end
        end
        if (p) last_pre = cyc;
        if (q) last_post = cyc;
    endtask

    task automatic step(input logic p, input logic q, input logic l,
                        input logic ld, input logic [7:0] v);
        pre_spike  = p;
        post_spike = q;
        learn_en   = l;
        w_load     = ld;
        w_load_val = v;
        @(posedge clk);
        model_edge(p, q, l, ld, v);
        #1;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        learn_en   = 1'b1;
        w_load     = 1'b0;
        w_load_val = 8'd0;
        got = {weight, update_w_flag, ltp_dir, time_diff};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        learn_en   = 1'b1;
        w_load     = 1'b0;
        w_load_val = 8'd0;
        model_reset();
        #12;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
            n_checks++;
            if (got !== {8'd128, 1'b0, 1'b0, 4'd0}) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got w=%0d f=%0b d=%0b t=%0d want w=128 f=0 d=0 t=0",
                         i, weight, update_w_flag, ltp_dir, time_diff);
            end
        end
    endtask

    task automatic test_ltp();
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd128);
        idle(16);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (got !== {8'd133, 1'b1, 1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL ltp_dt3 got w=%0d f=%0b d=%0b t=%0d want w=133 f=1 d=1 t=3",
                     weight, update_w_flag, ltp_dir, time_diff);
        end
        idle(1);
        n_checks++;
        if (got !== {8'd133, 1'b0, 1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL ltp_pulse_end got w=%0d f=%0b d=%0b t=%0d want w=133 f=0 d=1 t=3",
                     weight, update_w_flag, ltp_dir, time_diff);
        end
    endtask

    task automatic test_ltd();
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd128);
        idle(16);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        idle(1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (got !== {8'd122, 1'b1, 1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL ltd_dt2 got w=%0d f=%0b d=%0b t=%0d want w=122 f=1 d=0 t=2",
                     weight, update_w_flag, ltp_dir, time_diff);
        end
        idle(1);
        n_checks++;
        if (got !== {8'd122, 1'b0, 1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL ltd_pulse_end got w=%0d f=%0b want w=122 f=0", weight, update_w_flag);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd250);
        idle(16);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (got !== {8'd255, 1'b1, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL sat_high got w=%0d f=%0b d=%0b t=%0d want w=255 f=1 d=1 t=1",
                     weight, update_w_flag, ltp_dir, time_diff);
        end
        idle(16);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (got !== {8'd255, 1'b1, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL sat_high_hold got w=%0d f=%0b want w=255 f=1", weight, update_w_flag);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
        idle(16);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (got !== {8'd0, 1'b1, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL sat_low got w=%0d f=%0b d=%0b t=%0d want w=0 f=1 d=0 t=1",
                     weight, update_w_flag, ltp_dir, time_diff);
        end
    endtask

    task automatic test_no_update();
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd100);
        idle(16);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (weight !== 8'd100 || update_w_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL simultaneous got w=%0d f=%0b want w=100 f=0", weight, update_w_flag);
        end
        idle(16);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(15);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (weight !== 8'd100 || update_w_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL outside_window got w=%0d f=%0b want w=100 f=0", weight, update_w_flag);
        end
        idle(16);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(7);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (got !== {8'd100, 1'b1, 1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL zero_delta got w=%0d f=%0b d=%0b t=%0d want w=100 f=1 d=1 t=8",
                     weight, update_w_flag, ltp_dir, time_diff);
        end
        idle(16);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        n_checks++;
        if (got !== {8'd100, 1'b0, 1'b1, 4'd8}) begin
            n_fail++;
            $display("FAIL learn_off got w=%0d f=%0b d=%0b t=%0d want w=100 f=0 d=1 t=8",
                     weight, update_w_flag, ltp_dir, time_diff);
        end
        idle(16);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'd42);
        n_checks++;
        if (weight !== 8'd42 || update_w_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL load_priority got w=%0d f=%0b want w=42 f=0", weight, update_w_flag);
        end
    endtask

    task automatic test_reset_midop();
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'd200);
        idle(16);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        #4;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (weight !== 8'd128 || update_w_flag !== 1'b0 || time_diff !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset got w=%0d f=%0b t=%0d want w=128 f=0 t=0",
                     weight, update_w_flag, time_diff);
        end
        #2;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        n_checks++;
        if (got !== {8'd128, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_clears_timer got w=%0d f=%0b d=%0b t=%0d want w=128 f=0 d=0 t=0",
                     weight, update_w_flag, ltp_dir, time_diff);
        end
    endtask

    task automatic test_random();
        logic p;
        logic q;
        logic l;
        logic ld;
        logic [7:0] v;
        for (int i = 0; i < 600; i++) begin
            p  = ($urandom_range(0, 4) == 0);
            q  = ($urandom_range(0, 4) == 0);
            l  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 39) == 0);
            v  = 8'($urandom_range(0, 255));
            step(p, q, l, ld, v);
            n_checks++;
            if (got !== {8'(m_w), 1'(m_flag), 1'(m_dir), 4'(m_td)}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got w=%0d f=%0b d=%0b t=%0d want w=%0d f=%0d d=%0d t=%0d",
                         i, weight, update_w_flag, ltp_dir, time_diff, m_w, m_flag, m_dir, m_td);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ltp();
        test_ltd();
        test_saturation();
        test_no_update();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
